dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 1024, giving byte capacity of the memory array (power of two, 16..65536).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0, giving the byte address that maps to array byte 0.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_dmem_addr, input, 32, byte address of the access (any alignment).
REQ-006 SHALL have port i_dmem_ren, input, 1, read request this cycle.
REQ-007 SHALL have port i_dmem_wen, input, 1, write request this cycle.
REQ-008 SHALL have port i_dmem_wdata, input, 32, write data, little-endian.
REQ-009 SHALL have port i_dmem_mask, input, 4, byte enables; bit n selects byte addr+n and wdata[8n+7:8n].
REQ-010 SHALL have port o_dmem_rdata, output, 32, registered read data.
REQ-011 SHALL have port o_fault, output, 1, registered flag: previous-cycle access was out of range.
REQ-012 SHALL have port o_rd_count, output, 32, number of accepted in-range reads.
REQ-013 SHALL have port o_wr_count, output, 32, number of accepted in-range writes.

Function
REQ-014 SHALL compute offset = i_dmem_addr - BASE_ADDR (32-bit, modulo 2^32); access is in range iff offset <= DEPTH_BYTES-4.
REQ-015 SHALL, on rising edge with i_dmem_ren=1 and in range, load o_dmem_rdata = {mem[off+3],mem[off+2],mem[off+1],mem[off]}; one-cycle latency, mask ignored for reads.
REQ-016 SHALL, on rising edge with i_dmem_ren=0, load o_dmem_rdata = 32'h0.
REQ-017 SHALL, on rising edge with i_dmem_ren=1 and out of range, load o_dmem_rdata = 32'h0.
REQ-018 SHALL, on rising edge with i_dmem_wen=1 and in range, write mem[off+n] = wdata byte n for each n with mask[n]=1; unmasked bytes unchanged.
REQ-019 SHALL suppress all array writes for out-of-range accesses.
REQ-020 SHALL, when ren and wen are both 1 at the same edge and same bytes, return pre-write (old) data on o_dmem_rdata and commit the write.
REQ-021 SHALL load o_fault = (ren|wen) & out-of-range each edge; o_fault is 0 on cycles with no request.
REQ-022 SHALL treat wen=1 with mask=4'b0000 as a no-op write: no array change, o_wr_count unchanged, range check still drives o_fault.
REQ-023 SHALL increment o_rd_count by 1 per in-range read edge and o_wr_count by 1 per in-range write edge with nonzero mask; both wrap from 32'hFFFFFFFF to 0.
REQ-024 SHALL not reset or initialise array contents; contents persist across reset.

Reset
REQ-025 SHALL, while i_rst_n=0, asynchronously force o_dmem_rdata=0, o_fault=0, o_rd_count=0, o_wr_count=0 and ignore all requests.
REQ-026 SHALL, on deassertion of i_rst_n, accept requests starting at the first rising edge with i_rst_n=1; a request overlapping reset assertion is dropped entirely (no partial write).

Configuration
REQ-027 SHALL, when macro DMEM_RESPONDER_MMIO_EN is defined, decode word address BASE_ADDR+DEPTH_BYTES-4 as a halt register: any write with mask[0]=1 sets a sticky output o_halt (1 bit, reset 0) and does not modify the array; reads of that address return {31'h0,o_halt}.
REQ-028 SHALL, when DMEM_RESPONDER_MMIO_EN is undefined, omit port o_halt and treat that address as ordinary array storage.

Verification
REQ-029 SHALL cover: write addr=0x10 wdata=0xDEADBEEF mask=1111, then read 0x10 -> rdata=0xDEADBEEF one cycle after the read edge, o_wr_count=1, o_rd_count=1.
REQ-030 SHALL cover: after REQ-029, write 0x10 wdata=0x00000055 mask=0001, read 0x11 -> rdata=0x00DEADBE... first read 0x10 -> 0xDEADBE55.
REQ-031 SHALL cover: simultaneous ren+wen at 0x20 (old 0x11111111, wdata 0x22222222, mask 1111) -> rdata=0x11111111, next read -> 0x22222222.
REQ-032 SHALL cover: read addr=0x3FE (DEPTH 1024) -> rdata=0, o_fault=1 next cycle, o_rd_count unchanged; idle cycle -> o_fault=0.
REQ-033 SHALL cover: assert i_rst_n=0 mid-cycle with rdata=0xDEADBEEF -> rdata, counts, o_fault zero immediately without a clock edge; prior array data still readable after release.
REQ-034 SHALL cover (MMIO build): write 0x00000001 mask=0001 to 0x3FC -> o_halt=1 next cycle and stays 1; read 0x3FC -> 0x00000001.

Source files
------------

// File: rtl/dmem_responder.sv
// Byte-addressed data memory responder: registered 32-bit reads, byte-masked writes, any alignment.
// Define DMEM_RESPONDER_MMIO_EN to map the top word as a sticky halt register (adds port o_halt).
module dmem_responder #(
  parameter int          DEPTH_BYTES = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic [31:0] o_dmem_rdata,
  output logic        o_fault,
  output logic [31:0] o_rd_count,
  output logic [31:0] o_wr_count
`ifdef DMEM_RESPONDER_MMIO_EN
  ,
  output logic        o_halt
`endif
);

  localparam int AW        = $clog2(DEPTH_BYTES);
  localparam int RW        = AW - 2;
  localparam int ROWS      = DEPTH_BYTES / 4;
  localparam int LAST_WORD = DEPTH_BYTES - 4;

  // Request protocol: i_dmem_ren / i_dmem_wen are single-cycle valids with no ready;
  // every request seen at a rising edge with i_rst_n=1 is accepted, and its result
  // (rdata, fault) is visible for exactly the following cycle.

  logic [31:0]   w_offset;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic          w_any_req;
  logic          w_rd_hit;
  logic          w_wr_hit;
  logic          w_halt_sel;
  logic          w_arr_wr;
  logic [1:0]    w_lane     [4];
  logic [RW-1:0] w_bank_row [4];
  logic [3:0]    w_bank_we;
  logic [7:0]    w_bank_wd  [4];
  logic [7:0]    w_bank_rd  [4];
  logic [31:0]   w_rd_word;
  logic [31:0]   w_rd_data;

  logic [7:0]    r_mem [4][ROWS];
  logic [31:0]   r_rdata;
  logic          r_fault;
  logic [31:0]   r_rd_count;
  logic [31:0]   r_wr_count;
`ifdef DMEM_RESPONDER_MMIO_EN
  logic          r_halt;
`endif

  // Range check in modulo-2^32 arithmetic so addresses below BASE_ADDR wrap high and fault.
  assign w_offset   = i_dmem_addr - BASE_ADDR;
  assign w_in_range = (w_offset <= 32'(LAST_WORD));
  assign w_idx      = w_offset[AW-1:0];
  assign w_any_req  = i_dmem_ren | i_dmem_wen;
  assign w_rd_hit   = i_dmem_ren & w_in_range;
  assign w_wr_hit   = i_dmem_wen & w_in_range & (|i_dmem_mask);

`ifdef DMEM_RESPONDER_MMIO_EN
  assign w_halt_sel = w_in_range & (w_offset == 32'(LAST_WORD));
`else
  assign w_halt_sel = 1'b0;
`endif
  assign w_arr_wr   = w_wr_hit & ~w_halt_sel;

  // Storage is split into four byte banks by (offset mod 4) so an unaligned word touches
  // each bank exactly once; w_lane[b] is the request byte lane that lands in bank b.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      w_lane[b]     = 2'(b) - w_idx[1:0];
      w_bank_row[b] = RW'((w_idx + AW'(w_lane[b])) >> 2);
      w_bank_we[b]  = w_arr_wr & i_dmem_mask[w_lane[b]];
      w_bank_wd[b]  = i_dmem_wdata[8*w_lane[b] +: 8];
      w_bank_rd[b]  = r_mem[b][w_bank_row[b]];
    end
  end

  always_comb begin
    w_rd_word = 32'h0;
    for (int n = 0; n < 4; n++) begin
      w_rd_word[8*n +: 8] = w_bank_rd[w_idx[1:0] + 2'(n)];
    end
  end

`ifdef DMEM_RESPONDER_MMIO_EN
  assign w_rd_data = w_halt_sel ? {31'h0, r_halt} : w_rd_word;
`else
  assign w_rd_data = w_rd_word;
`endif

  // Array has no reset branch: contents survive reset, but no write lands while held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata    <= 32'h0;
      r_fault    <= 1'b0;
      r_rd_count <= 32'h0;
      r_wr_count <= 32'h0;
    end else begin
      r_rdata <= w_rd_hit ? w_rd_data : 32'h0;
      r_fault <= w_any_req & ~w_in_range;
      if (w_rd_hit) begin
        r_rd_count <= r_rd_count + 32'd1;
      end
      if (w_wr_hit) begin
        r_wr_count <= r_wr_count + 32'd1;
      end
      for (int b = 0; b < 4; b++) begin
        if (w_bank_we[b]) begin
          r_mem[b][w_bank_row[b]] <= w_bank_wd[b];
        end
      end
    end
  end

`ifdef DMEM_RESPONDER_MMIO_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_halt <= 1'b0;
    end else if (w_wr_hit & w_halt_sel & i_dmem_mask[0]) begin
      r_halt <= 1'b1;
    end
  end

  assign o_halt = r_halt;
`endif

  assign o_dmem_rdata = r_rdata;
  assign o_fault      = r_fault;
  assign o_rd_count   = r_rd_count;
  assign o_wr_count   = r_wr_count;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// compared against a byte-array reference model kept in the bench.
module tb_dmem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic        ren;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic [31:0] rdata;
  logic        fault;
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`ifdef DMEM_RESPONDER_MMIO_EN
  logic        halt;
`endif

  dmem_responder #(.DEPTH_BYTES(DEPTH), .BASE_ADDR(BASE)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_dmem_addr  (addr),
    .i_dmem_ren   (ren),
    .i_dmem_wen   (wen),
    .i_dmem_wdata (wdata),
    .i_dmem_mask  (mask),
    .o_dmem_rdata (rdata),
    .o_fault      (fault),
    .o_rd_count   (rd_count),
    .o_wr_count   (wr_count)
`ifdef DMEM_RESPONDER_MMIO_EN
    ,
    .o_halt       (halt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // scoreboard state
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  m_mem [DEPTH];
  logic [31:0] m_rd;
  logic [31:0] m_wr;
  logic        m_halt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One request cycle: model predicts, inputs driven, edge, outputs checked at edge+1.
  task automatic do_cycle(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m);
    logic [31:0] off;
    logic [31:0] e;
    bit          inr;
    bit          hsel;
    bit          fe;
    off  = a - BASE;
    inr  = (off <= 32'(DEPTH - 4));
    hsel = 1'b0;
`ifdef DMEM_RESPONDER_MMIO_EN
    hsel = inr && (off == 32'(DEPTH - 4));
`endif
    e = 32'h0;
    if (r && inr) begin
      if (hsel) e = {31'h0, m_halt};
      else      e = {m_mem[off+3], m_mem[off+2], m_mem[off+1], m_mem[off]};
    end
    exp_q.push_back(e);
    fe = (r || w) && !inr;
    if (r && inr) m_rd = m_rd + 1;
    if (w && inr && m != 4'b0000) begin
      m_wr = m_wr + 1;
      if (hsel) begin
        if (m[0]) m_halt = 1'b1;
      end else begin
        for (int n = 0; n < 4; n++)
          if (m[n]) m_mem[off+n] = d[8*n +: 8];
      end
    end
    ren = r; wen = w; addr = a; wdata = d; mask = m;
    @(posedge clk);
    #1;
    check("rdata", rdata, exp_q.pop_front());
    check("fault", {31'h0, fault}, {31'h0, fe});
    check("rd_count", rd_count, m_rd);
    check("wr_count", wr_count, m_wr);
`ifdef DMEM_RESPONDER_MMIO_EN
    check("halt", {31'h0, halt}, {31'h0, m_halt});
`endif
  endtask

  task automatic idle();
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Reset asserted mid-cycle with a write pending; the write must be dropped.
  task automatic reset_mid();
    ren = 1'b0; wen = 1'b1; addr = 32'h10; wdata = 32'hFFFF_FFFF; mask = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_fault", {31'h0, fault}, 32'h0);
    check("rst_rd_count", rd_count, 32'h0);
    check("rst_wr_count", wr_count, 32'h0);
    m_rd = 0; m_wr = 0; m_halt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hold_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    wen = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel <= 4)      return BASE + 32'($urandom_range(0, 63));
    else if (sel <= 6) return BASE + 32'($urandom_range(0, DEPTH - 4));
    else if (sel == 7) return BASE + 32'($urandom_range(DEPTH - 8, DEPTH - 4));
    else if (sel == 8) return BASE + 32'($urandom_range(DEPTH - 3, DEPTH + 8));
    else               return $urandom;
  endfunction

  initial begin
    rst_n = 1'b1; ren = 1'b0; wen = 1'b0; addr = 32'h0; wdata = 32'h0; mask = 4'h0;
    m_rd = 0; m_wr = 0; m_halt = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;

    #1 rst_n = 1'b0;
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_fault", {31'h0, fault}, 32'h0);
    check("reset_rd_count", rd_count, 32'h0);
    check("reset_wr_count", wr_count, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // zero-fill so the array has known contents
    for (int i = 0; i < DEPTH / 4; i++) do_cycle(1'b0, 1'b1, BASE + 32'(4 * i), 32'h0, 4'hF);
    do_cycle(1'b0, 1'b1, BASE + 32'(DEPTH - 5), 32'h0, 4'hE);

    // counts restart from zero; array contents must persist
    @(posedge clk);
    reset_mid();

    // write/read word, then byte merge and unaligned read
    do_cycle(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    do_cycle(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    check("req29_rdata", rdata, 32'hDEAD_BEEF);
    check("req29_counts", {wr_count[15:0], rd_count[15:0]}, 32'h0001_0001);
    do_cycle(1'b0, 1'b1, 32'h10, 32'h0000_0055, 4'h1);
    do_cycle(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    check("req30_rdata_10", rdata, 32'hDEAD_BE55);
    do_cycle(1'b1, 1'b0, 32'h11, 32'h0, 4'h0);
    check("req30_rdata_11", rdata, 32'h00DE_ADBE);

    // simultaneous read+write returns old data
    do_cycle(1'b0, 1'b1, 32'h20, 32'h1111_1111, 4'hF);
    do_cycle(1'b1, 1'b1, 32'h20, 32'h2222_2222, 4'hF);
    check("req31_old", rdata, 32'h1111_1111);
    do_cycle(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    check("req31_new", rdata, 32'h2222_2222);

    // range boundaries, zero-mask write, wrapped addresses
    do_cycle(1'b1, 1'b0, BASE + 32'h3FE, 32'h0, 4'h0);
    check("req32_fault", {31'h0, fault}, 32'h1);
    idle();
    check("req32_idle_fault", {31'h0, fault}, 32'h0);
    do_cycle(1'b1, 1'b0, BASE + 32'h3FB, 32'h0, 4'h0);
    do_cycle(1'b1, 1'b0, BASE + 32'h3FD, 32'h0, 4'h0);
    do_cycle(1'b0, 1'b1, BASE + 32'h400, 32'hA5A5_A5A5, 4'hF);
    do_cycle(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0);
    do_cycle(1'b0, 1'b1, 32'h20, 32'h3333_3333, 4'h0);
    do_cycle(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);

    // reset with live rdata; data survives
    do_cycle(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    do_cycle(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    check("req33_pre", rdata, 32'hDEAD_BEEF);
    reset_mid();
    do_cycle(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    check("req33_post", rdata, 32'hDEAD_BEEF);

`ifdef DMEM_RESPONDER_MMIO_EN
    do_cycle(1'b0, 1'b1, BASE + 32'h3FC, 32'h0000_0001, 4'h1);
    check("req34_halt", {31'h0, halt}, 32'h1);
    idle();
    idle();
    check("req34_sticky", {31'h0, halt}, 32'h1);
    do_cycle(1'b1, 1'b0, BASE + 32'h3FC, 32'h0, 4'h0);
    check("req34_read", rdata, 32'h1);
`endif

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic r;
      logic w;
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      do_cycle(r, w, rand_addr(), $urandom, 4'($urandom_range(0, 15)));
    end

    // read back a window to flush out stale model/array differences
    for (int i = 0; i < 64; i++) do_cycle(1'b1, 1'b0, BASE + 32'(i), 32'h0, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
